// File: rtl/bus_arbiter_2m.sv
// Two-master, one-slave arbiter for the req/ack/resp system bus.
// One transaction in flight at a time; a watchdog aborts transactions stuck on a dead slave.
module bus_arbiter_2m #(
  parameter bit          FIXED_PRIO = 1'b0,
  parameter int          TIMEOUT    = 1023,
  parameter logic [31:0] ERR_RDATA  = 32'hDEADBEEF
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        m0_req_i,
  input  logic        m0_we_i,
  input  logic [31:0] m0_addr_i,
  input  logic [3:0]  m0_be_i,
  input  logic [31:0] m0_wdata_i,
  output logic        m0_ack_o,
  output logic        m0_resp_o,
  output logic [31:0] m0_rdata_o,
  input  logic        m1_req_i,
  input  logic        m1_we_i,
  input  logic [31:0] m1_addr_i,
  input  logic [3:0]  m1_be_i,
  input  logic [31:0] m1_wdata_i,
  output logic        m1_ack_o,
  output logic        m1_resp_o,
  output logic [31:0] m1_rdata_o,
  output logic        s_req_o,
  output logic        s_we_o,
  output logic [31:0] s_addr_o,
  output logic [3:0]  s_be_o,
  output logic [31:0] s_wdata_o,
  input  logic        s_ack_i,
  input  logic        s_resp_i,
  input  logic [31:0] s_rdata_i,
  output logic        gnt_o,
  output logic        busy_o,
  output logic        timeout_o
);

  localparam int CW = $clog2(TIMEOUT);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t      state;
  logic        gnt;
  logic        we_r;
  logic [31:0] addr_r;
  logic [3:0]  be_r;
  logic [31:0] wdata_r;
  logic [CW-1:0] wd;
  logic        tmo_r;

  logic        win;
  logic        expire;
  logic        ack_ev;
  logic        resp_ev;
  logic [31:0] rsp_data;

  // On a tie the round-robin mode favours whichever master did not get the last grant.
  function automatic logic pick_winner(input logic r0, input logic r1, input logic last);
    if (r0 && r1) return FIXED_PRIO ? 1'b0 : ~last;
    return ~r0;
  endfunction

  always_comb begin
    win      = pick_winner(m0_req_i, m1_req_i, gnt);
    expire   = (wd == CW'(TIMEOUT - 1));
    ack_ev   = (state == REQ) && (s_ack_i || expire);
    // A read aborted while still waiting for ack owes its master a response too.
    resp_ev  = ((state == REQ) && expire && !s_ack_i && !we_r) ||
               ((state == RESP) && (s_resp_i || expire));
    rsp_data = ((state == RESP) && s_resp_i) ? s_rdata_i : ERR_RDATA;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state   <= IDLE;
      gnt     <= 1'b0;
      we_r    <= 1'b0;
      addr_r  <= '0;
      be_r    <= '0;
      wdata_r <= '0;
      wd      <= '0;
      tmo_r   <= 1'b0;
    end else begin
      tmo_r <= 1'b0;
      case (state)
        IDLE: begin
          if (m0_req_i || m1_req_i) begin
            gnt     <= win;
            we_r    <= win ? m1_we_i    : m0_we_i;
            addr_r  <= win ? m1_addr_i  : m0_addr_i;
            be_r    <= win ? m1_be_i    : m0_be_i;
            wdata_r <= win ? m1_wdata_i : m0_wdata_i;
            wd      <= '0;
            state   <= REQ;
          end
        end
        REQ: begin
          if (s_ack_i) begin
            wd    <= '0;
            state <= we_r ? IDLE : RESP;
          end else if (expire) begin
            tmo_r <= 1'b1;
            state <= IDLE;
          end else begin
            wd <= wd + CW'(1);
          end
        end
        RESP: begin
          if (s_resp_i) begin
            state <= IDLE;
          end else if (expire) begin
            tmo_r <= 1'b1;
            state <= IDLE;
          end else begin
            wd <= wd + CW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign s_req_o    = (state == REQ);
  assign s_we_o     = we_r;
  assign s_addr_o   = addr_r;
  assign s_be_o     = be_r;
  assign s_wdata_o  = wdata_r;
  assign gnt_o      = gnt;
  assign busy_o     = (state != IDLE);
  assign timeout_o  = tmo_r;

  assign m0_ack_o   = ack_ev && !gnt;
  assign m1_ack_o   = ack_ev && gnt;
  assign m0_resp_o  = resp_ev && !gnt;
  assign m1_resp_o  = resp_ev && gnt;
  assign m0_rdata_o = (resp_ev && !gnt) ? rsp_data : 32'h0;
  assign m1_rdata_o = (resp_ev && gnt) ? rsp_data : 32'h0;

endmodule
